// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (sign/zero/upper/branch) with a valid/ready handshake and a 2-entry skid buffer.
// Optional output-transfer counter (xfer_cnt, clr_cnt) is built only when IMM_EXT_CNT_EN is defined.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_CNT_EN
    ,
    input  logic             clr_cnt,
    output logic [15:0]      xfer_cnt
`endif
);

    generate
        if (OUT_W < IN_W + 2) begin : g_bad_width
            $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [OUT_W-1:0]   skid_data_q, skid_data_d;
    logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
    logic [OUT_W-1:0]   sext;
    logic [OUT_W-1:0]   ext;
    logic               in_fire;
    logic               out_fire;

    always_comb begin
        sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
        ext  = sext;
        case (in_mode)
            2'b00:   ext = sext;
            2'b01:   ext = {{(OUT_W-IN_W){1'b0}}, in_data};
            2'b10:   ext = {in_data, {(OUT_W-IN_W){1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    // Handshake flags come from registered state only, so in_ready never depends on out_ready.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign out_data  = data_q;
    assign out_tag   = tag_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tag_d       = tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    data_d  = ext;
                    tag_d   = in_tag;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    data_d = ext;
                    tag_d  = in_tag;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire) begin
                    skid_data_d = ext;
                    skid_tag_d  = in_tag;
                    state_d     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    data_d  = skid_data_q;
                    tag_d   = skid_tag_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            data_q      <= '0;
            tag_q       <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // A clear in the same cycle as a transfer leaves the count at 1, not 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = out_fire ? 16'd1 : 16'd0;
        end else if (out_fire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: directed mode/backpressure/streaming/reset/width steps plus a random phase,
// all scored against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_data;

    logic        d12_in_valid, d12_in_ready, d12_out_valid, d12_out_ready;
    logic [11:0] d12_in_data;
    logic [1:0]  d12_in_mode;
    logic [4:0]  d12_in_tag, d12_out_tag;
    logic [15:0] d12_out_data;

`ifdef IMM_EXT_CNT_EN
    logic        clr_cnt, d12_clr_cnt;
    logic [15:0] xfer_cnt, d12_xfer_cnt;
    logic [15:0] cnt_model;
`endif

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
`ifdef IMM_EXT_CNT_EN
        , .clr_cnt(clr_cnt), .xfer_cnt(xfer_cnt)
`endif
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .TAG_W(5)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d12_in_valid), .in_ready(d12_in_ready), .in_data(d12_in_data),
        .in_mode(d12_in_mode), .in_tag(d12_in_tag),
        .out_valid(d12_out_valid), .out_ready(d12_out_ready),
        .out_data(d12_out_data), .out_tag(d12_out_tag)
`ifdef IMM_EXT_CNT_EN
        , .clr_cnt(d12_clr_cnt), .xfer_cnt(d12_xfer_cnt)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit quiet        = 1'b0;

    logic [31:0] exp_d[$];
    logic [4:0]  exp_t[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Extension computed from the integer value of the immediate, reduced modulo 2^out_w.
    function automatic logic [63:0] ref_ext(input int in_w, input int out_w,
                                            input logic [63:0] d, input logic [1:0] m);
        longint      s;
        logic [63:0] mask, r;
        mask = (64'd1 << out_w) - 64'd1;
        if (d >= (64'd1 << (in_w - 1))) s = longint'(d) - longint'(64'd1 << in_w);
        else                            s = longint'(d);
        case (m)
            2'd0:    r = s;
            2'd1:    r = d;
            2'd2:    r = d << (out_w - in_w);
            default: r = s * 4;
        endcase
        return r & mask;
    endfunction

    // Scoreboard: queue occupancy predicts in_ready/out_valid, queue head predicts output word.
    always @(negedge clk) begin
        logic [63:0] r64;
        if (!rst_n) begin
            exp_d.delete();
            exp_t.delete();
`ifdef IMM_EXT_CNT_EN
            cnt_model = 16'd0;
`endif
        end else begin
            chk("in_ready", in_ready, exp_d.size() < 2);
            chk("out_valid", out_valid, exp_d.size() > 0);
            if (exp_d.size() > 0) begin
                chk("out_data", out_data, exp_d[0]);
                chk("out_tag", out_tag, exp_t[0]);
            end
`ifdef IMM_EXT_CNT_EN
            chk("xfer_cnt", xfer_cnt, cnt_model);
            if (clr_cnt) cnt_model = (out_valid && out_ready) ? 16'd1 : 16'd0;
            else if (out_valid && out_ready) cnt_model = cnt_model + 16'd1;
`endif
            if (out_valid && out_ready && exp_d.size() > 0) begin
                if (!quiet) $display("[TB] out data=%h tag=%0d", out_data, out_tag);
                void'(exp_d.pop_front());
                void'(exp_t.pop_front());
            end
            if (in_valid && in_ready) begin
                r64 = ref_ext(16, 32, {48'd0, in_data}, in_mode);
                exp_d.push_back(r64[31:0]);
                exp_t.push_back(in_tag);
            end
        end
    end

    task automatic send16(input logic [15:0] d, input logic [1:0] m, input logic [4:0] t,
                          input logic [31:0] e, input string name);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(name, out_data, e);
        chk({name, "_tag"}, out_tag, t);
        chk({name, "_vld"}, out_valid, 1'b1);
    endtask

    task automatic send12(input logic [11:0] d, input logic [1:0] m,
                          input logic [15:0] e, input string name);
        @(posedge clk); #1;
        d12_in_valid = 1'b1; d12_in_data = d; d12_in_mode = m; d12_in_tag = 5'd7;
        @(posedge clk); #1;
        d12_in_valid = 1'b0;
        @(negedge clk);
        chk(name, d12_out_data, e);
        chk({name, "_vld"}, d12_out_valid, 1'b1);
        $display("[TB] w12 data=%h mode=%0d out=%h", d, m, d12_out_data);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
        d12_in_valid = 1'b0; d12_in_data = '0; d12_in_mode = '0; d12_in_tag = '0; d12_out_ready = 1'b1;
`ifdef IMM_EXT_CNT_EN
        clr_cnt = 1'b0; d12_clr_cnt = 1'b0; cnt_model = 16'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send16(16'h8001, 2'b00, 5'd3, 32'hFFFF8001, "mode_sign");
        send16(16'h8001, 2'b01, 5'd4, 32'h00008001, "mode_zero");
        send16(16'h8001, 2'b10, 5'd5, 32'h80010000, "mode_upper");
        send16(16'h8001, 2'b11, 5'd6, 32'hFFFE0004, "mode_branch");

        // Backpressure: fill both entries, hold a third word, then drain in order.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0003; in_mode = 2'b00; in_tag = 5'd1;
        @(posedge clk); #1;
        in_data = 16'h7FFF; in_tag = 5'd2;
        @(posedge clk); #1;
        in_data = 16'h1234; in_mode = 2'b01; in_tag = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_hold_data", out_data, 32'h00000003);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", {out_tag, out_data}, {5'd1, 32'h00000003});
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_second", {out_tag, out_data}, {5'd2, 32'h00007FFF});
        chk("bp_in_ready_back", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third", {out_tag, out_data}, {5'd3, 32'h00001234});

        // Streaming: 10 back-to-back words, one output per cycle.
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 10); in_data = 16'(16'h0100 + i); in_mode = 2'b01; in_tag = 5'(i);
            @(negedge clk);
            if (i > 0) begin
                chk("stream_vld", out_valid, 1'b1);
                chk("stream_data", out_data, 32'(32'h0100 + i - 1));
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset while FULL must clear outputs asynchronously.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00AA; in_mode = 2'b00; in_tag = 5'd9;
        @(posedge clk); #1;
        in_data = 16'h00BB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_out_data", out_data, 32'd0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 1'b0);
        end

        send12(12'h800, 2'b00, 16'hF800, "w12_sign");
        send12(12'h800, 2'b10, 16'h8000, "w12_upper");
        send12(12'h800, 2'b11, 16'hE000, "w12_branch");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
`ifdef IMM_EXT_CNT_EN
            clr_cnt   = ($urandom_range(0, 31) == 0);
`endif
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
`ifdef IMM_EXT_CNT_EN
        clr_cnt = 1'b0;
`endif
        repeat (4) @(posedge clk);
        #1;

`ifdef IMM_EXT_CNT_EN
        quiet = 1'b1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("cnt_cleared", xfer_cnt, 16'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = 2'b00; in_data = 16'd0;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk); #1;
            in_data = 16'(i + 1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_ffff", xfer_cnt, 16'hFFFF);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_wrap", xfer_cnt, 16'h0000);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("cnt_clr_with_xfer", xfer_cnt, 16'd1);
        quiet = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate-extension stage for the datapath, the next generation of the plain 16->32 sign extender.
- Supports four extension modes (sign, zero, upper-load, branch-offset) and arbitrary input/output widths.
- Sits between decode and the ALU operand mux, with a valid/ready handshake and a 2-entry skid buffer so a stalled consumer never drops an immediate.

Parameters:
- IN_W, 16, width of the raw immediate field.
- OUT_W, 32, width of the extended operand; legal only if OUT_W >= IN_W+2 (elaboration error otherwise).
- TAG_W, 5, width of the sideband tag carried alongside the data (e.g. destination register).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has an immediate.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  IN_W  raw immediate.
- in_mode  in  2  00 sign, 01 zero, 10 upper, 11 branch.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  extended result available.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag matching out_data.

Behaviour:
- Reset (async assert, sync-safe deassert) gives: out_valid=0, out_data=0, out_tag=0, skid empty, state EMPTY, in_ready=1.
- Extension is computed combinationally on input, then registered:
  - 00: {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}.
  - 01: zero-filled upper bits.
  - 10: in_data placed at bits [OUT_W-1 : OUT_W-IN_W], low bits 0.
  - 11: sign-extended value shifted left 2; low 2 bits 0; top bits dropped (mod 2^OUT_W).
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid when the output register is free. Throughput is 1 per cycle while out_ready=1.
- State machine:
  - EMPTY: out_valid=0.
    - Input transfer -> ONE, output register loaded.
  - ONE: out_valid=1.
    - Input & output transfer together -> stay ONE; output register reloads with the new word.
    - Output transfer only -> EMPTY.
    - Input transfer only -> FULL; the new word goes to the skid register.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer -> ONE; skid word moves to the output register.
- in_ready = (state != FULL). It is decoded from registered state only, with no combinational path from out_ready.
- in_valid is ignored whenever in_ready=0; no data is lost or duplicated.
- out_data and out_tag hold stable while out_valid=1 & out_ready=0.
- Ordering is strictly FIFO.
- Reset mid-operation flushes both entries immediately; there is no partial output.

Optional Feature:
- Macro IMM_EXT_CNT_EN.
- When defined:
  - Adds output port xfer_cnt (out, 16) counting output transfers.
  - Resets to 0 and wraps 0xFFFF -> 0x0000.
  - Adds input clr_cnt (in, 1), which synchronously zeroes the count. If a transfer occurs in the same cycle, the count becomes 1.
- When undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Modes, IN_W=16, OUT_W=32, out_ready=1:
  - 0x8001 mode 00 -> 0xFFFF8001.
  - mode 01 -> 0x00008001.
  - mode 10 -> 0x80010000.
  - mode 11 -> 0xFFFE0004.
  - Each result appears one cycle after the transfer, with the tag preserved.
- Backpressure: hold out_ready=0 and send 0x0003 (tag 1) then 0x7FFF (tag 2).
  - in_ready drops to 0 after the second word and stays 0 while a third word is held on in_valid.
  - Release out_ready: outputs are 0x00000003/1 then 0x00007FFF/2, then the third word, in order with no loss.
- Streaming: in_valid=out_ready=1 for 10 cycles with incrementing data -> 10 consecutive outputs, out_valid continuously 1 after the first cycle.
- Reset: assert rst_n=0 in FULL state -> out_valid=0, out_data=0 and in_ready=1 immediately, without waiting for a clock edge; after release, no stale word is emitted.
- Width parametrisation: IN_W=12, OUT_W=16, 0x800 mode 00 -> 0xF800; mode 10 -> 0x8000; mode 11 -> 0xE000.
- IMM_EXT_CNT_EN defined:
  - 0xFFFF transfers then one more -> xfer_cnt=0x0000.
  - clr_cnt together with a transfer -> xfer_cnt=1.
